// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter over four requesters with a bounded grant tenure.
// The granted requester's data is forwarded through an internal 4:1 mux.
module rr_mux4_arbiter #(
  parameter int DATA_W   = 1,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  output logic [3:0]        gnt,
  output logic [1:0]        sel,
  output logic              busy,
  output logic [DATA_W-1:0] y
);

  localparam int HCW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [HCW-1:0] HOLD_LIM = HCW'(HOLD_MAX);
  localparam logic [HCW-1:0] HOLD_ONE = HCW'(1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      last_q, last_d;
  logic [HCW-1:0]  hold_q, hold_d;

  logic [3:0]      cand;
  logic [1:0]      win;
  logic [1:0]      idx;
  logic            found;
  logic            cur_req;
  logic            at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= 2'd3;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  // The current holder is masked out, so a rotate never re-picks it.
  assign cand    = (state_q == GRANT) ? (req & ~gnt_q) : req;
  assign cur_req = |(req & gnt_q);
  assign at_max  = (HOLD_MAX != 0) && (hold_q == HOLD_LIM);

  always_comb begin
    found = 1'b0;
    win   = last_q;
    idx   = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          last_d  = win;
          hold_d  = HOLD_ONE;
        end
      end
      GRANT: begin
        if ((!cur_req || at_max) && found) begin
          gnt_d  = 4'b0001 << win;
          sel_d  = win;
          last_d = win;
          hold_d = HOLD_ONE;
        end else if (!cur_req) begin
          state_d = IDLE;
          gnt_d   = '0;
          hold_d  = '0;
        end else if (HOLD_MAX != 0 && !at_max) begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = (state_q == GRANT);

  always_comb begin
    y = '0;
    if (busy) begin
      case (sel_q)
        2'd0:    y = d0;
        2'd1:    y = d1;
        2'd2:    y = d2;
        default: y = d3;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter.
// Stimulus queues hand-computed expectations; a monitor pops and compares.
module tb_rr_mux4_arbiter;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       y;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [0:0] d0, d1, d2, d3;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic [0:0] y;

  logic [3:0] dv;
  exp_t       q[$];
  int         checks;
  int         failures;

  rr_mux4_arbiter #(
    .DATA_W(1),
    .HOLD_MAX(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .d0(d0),
    .d1(d1),
    .d2(d2),
    .d3(d3),
    .gnt(gnt),
    .sel(sel),
    .busy(busy),
    .y(y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign d0 = dv[0];
  assign d1 = dv[1];
  assign d2 = dv[2];
  assign d3 = dv[3];

  task automatic push(input logic [3:0] g, input logic [1:0] s,
                      input logic b, input string nm);
    exp_t e;
    e.gnt  = g;
    e.sel  = s;
    e.busy = b;
    e.y    = b ? dv[s] : 1'b0;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] g,
                      input logic [1:0] s, input logic b, input string nm);
    @(negedge clk);
    req = r;
    push(g, s, b, nm);
  endtask

  task automatic async_reset(input string nm);
    @(negedge clk);
    #2;
    push(4'b0000, 2'b00, 1'b0, nm);
    req   = 4'b0000;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cmp(input string nm, input string f,
                     input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%b expected=%b", nm, f, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp(e.name, "gnt", gnt, e.gnt);
      cmp(e.name, "sel", {2'b00, sel}, {2'b00, e.sel});
      cmp(e.name, "busy", {3'b000, busy}, {3'b000, e.busy});
      cmp(e.name, "y", {3'b000, y}, {3'b000, e.y});
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    dv       = 4'b1101;
    req      = 4'b0000;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    step(4'b0000, 4'b0000, 2'd0, 1'b0, "reset_state");

    step(4'b0100, 4'b0100, 2'd2, 1'b1, "single_grant");
    step(4'b0100, 4'b0100, 2'd2, 1'b1, "single_hold");
    step(4'b0000, 4'b0000, 2'd2, 1'b0, "single_release");

    step(4'b1000, 4'b1000, 2'd3, 1'b1, "pre_reset_grant");
    async_reset("async_reset");

    for (int k = 0; k < 20; k++) begin
      logic [3:0] g;
      g = 4'b0001 << ((k / 4) % 4);
      step(4'b1111, g, 2'((k / 4) % 4), 1'b1, "full_load");
    end

    step(4'b0000, 4'b0000, 2'd0, 1'b0, "load_idle");
    step(4'b0001, 4'b0001, 2'd0, 1'b1, "early_grant0");
    step(4'b1001, 4'b0001, 2'd0, 1'b1, "early_pending3");
    step(4'b1000, 4'b1000, 2'd3, 1'b1, "early_switch");
    step(4'b0000, 4'b0000, 2'd3, 1'b0, "early_idle");

    for (int k = 0; k < 10; k++)
      step(4'b0010, 4'b0010, 2'd1, 1'b1, "lone_req");
    step(4'b0011, 4'b0001, 2'd0, 1'b1, "lone_saturated_rotate");
    step(4'b0000, 4'b0000, 2'd0, 1'b0, "lone_idle");

    step(4'b0100, 4'b0100, 2'd2, 1'b1, "grant2");
    async_reset("reset_in_grant2");
    step(4'b1010, 4'b0010, 2'd1, 1'b1, "contend_first");
    step(4'b1010, 4'b0010, 2'd1, 1'b1, "contend_hold");
    step(4'b1000, 4'b1000, 2'd3, 1'b1, "contend_drop1");
    step(4'b0000, 4'b0000, 2'd3, 1'b0, "contend_idle");

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
